// File: rtl/spi1_master_arbiter_pkg.sv
// Shared definitions for the SPI-1 master arbiter: state encoding, default
// timing parameters and the round-robin channel picker.
package spi1_master_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi1_state_t;

    localparam int SPI1_DATA_BITS = 32;
    localparam int SPI1_SCLK_HALF = 50;
    localparam int SPI1_CS_SETUP  = 10;
    localparam int SPI1_CS_HOLD   = 10;
    localparam int SPI1_CS_GAP    = 20;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Returns {found, index}; searches ptr+1, ptr+2, ptr+3, ptr (mod 4).
    // Walking offsets downward lets the nearest requester overwrite the result.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

endpackage

// File: rtl/spi1_shift_engine.sv
// Mode-3 SPI shift engine: chip-select setup, MSB-first shifting, hold and
// inter-frame gap timing, with a start/done handshake and a 2-flop miso sync.
module spi1_shift_engine
    import spi1_master_arbiter_pkg::*;
#(
    parameter int DATA_BITS = SPI1_DATA_BITS,
    parameter int SCLK_HALF = SPI1_SCLK_HALF,
    parameter int CS_SETUP  = SPI1_CS_SETUP,
    parameter int CS_HOLD   = SPI1_CS_HOLD,
    parameter int CS_GAP    = SPI1_CS_GAP
)
(
    input  logic                 clk_100m,
    input  logic                 rst_syn,
    input  logic                 i_start,
    input  logic [DATA_BITS-1:0] i_tx,
    input  logic                 i_miso,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_mclk,
    output logic                 o_mosi,
    output logic [DATA_BITS-1:0] o_rx
);

    localparam int PH_MAX = max_int(max_int(2 * SCLK_HALF, CS_SETUP), max_int(CS_HOLD, CS_GAP));
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [PH_W-1:0]  PH_SETUP  = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]  PH_BIT    = PH_W'(2 * SCLK_HALF - 1);
    localparam logic [PH_W-1:0]  PH_RISE   = PH_W'(SCLK_HALF);
    localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(SCLK_HALF - 1);
    localparam logic [PH_W-1:0]  PH_HOLD   = PH_W'(CS_HOLD - 1);
    localparam logic [PH_W-1:0]  PH_GAP    = PH_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_BITS - 1);

    spi1_state_t          r_state, w_state;
    logic [PH_W-1:0]      r_phase, w_phase;
    logic [BIT_W-1:0]     r_bits, w_bits;
    logic [DATA_BITS-1:0] r_tx_sr, w_tx_sr;
    logic [DATA_BITS-1:0] r_rx_sr, w_rx_sr;
    logic [DATA_BITS-1:0] r_rx, w_rx;
    logic                 r_mclk, w_mclk;
    logic                 r_mosi, w_mosi;
    logic                 r_done, w_done;
    logic [1:0]           r_sync;

    always_comb begin
        w_state = r_state;
        w_phase = r_phase;
        w_bits  = r_bits;
        w_tx_sr = r_tx_sr;
        w_rx_sr = r_rx_sr;
        w_rx    = r_rx;
        w_mclk  = r_mclk;
        w_mosi  = r_mosi;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state = ST_SETUP;
                    w_phase = PH_SETUP;
                    w_tx_sr = i_tx;
                    w_mosi  = i_tx[DATA_BITS-1];
                    w_mclk  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (r_phase == '0) begin
                    w_state = ST_SHIFT;
                    w_phase = PH_BIT;
                    w_bits  = BITS_LAST;
                    w_mclk  = 1'b0;
                end else begin
                    w_phase = r_phase - 1'b1;
                end
            end
            ST_SHIFT: begin
                // First high cycle: the synchroniser already reflects this bit's miso.
                if (r_phase == PH_SAMPLE) w_rx_sr = {r_rx_sr[DATA_BITS-2:0], r_sync[1]};
                if (r_phase == '0) begin
                    if (r_bits == '0) begin
                        w_state = ST_HOLD;
                        w_phase = PH_HOLD;
                    end else begin
                        w_phase = PH_BIT;
                        w_bits  = r_bits - 1'b1;
                        w_mclk  = 1'b0;
                        w_tx_sr = {r_tx_sr[DATA_BITS-2:0], 1'b0};
                        w_mosi  = r_tx_sr[DATA_BITS-2];
                    end
                end else begin
                    w_phase = r_phase - 1'b1;
                    if (r_phase == PH_RISE) w_mclk = 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_phase == '0) begin
                    w_state = ST_GAP;
                    w_phase = PH_GAP;
                    w_done  = 1'b1;
                    w_rx    = r_rx_sr;
                end else begin
                    w_phase = r_phase - 1'b1;
                end
            end
            ST_GAP: begin
                w_mosi = 1'b1;
                if (r_phase == '0) w_state = ST_IDLE;
                else               w_phase = r_phase - 1'b1;
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100m) begin
        if (rst_syn) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_bits  <= '0;
            r_rx    <= '0;
            r_mclk  <= 1'b1;
            r_mosi  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_phase <= w_phase;
            r_bits  <= w_bits;
            r_rx    <= w_rx;
            r_mclk  <= w_mclk;
            r_mosi  <= w_mosi;
            r_done  <= w_done;
        end
    end

    always_ff @(posedge clk_100m) begin
        r_tx_sr <= w_tx_sr;
        r_rx_sr <= w_rx_sr;
        r_sync  <= {r_sync[0], i_miso};
    end

    assign o_busy = (r_state != ST_IDLE);
    assign o_done = r_done;
    assign o_mclk = r_mclk;
    assign o_mosi = r_mosi;
    assign o_rx   = r_rx;

endmodule

// File: rtl/spi1_master_arbiter.sv
// Round-robin arbiter sharing the SPI-1 master bus among four requesters,
// one per chip select, in front of a single mode-3 shift engine.
module spi1_master_arbiter
    import spi1_master_arbiter_pkg::*;
#(
    parameter int DATA_BITS = SPI1_DATA_BITS,
    parameter int SCLK_HALF = SPI1_SCLK_HALF,
    parameter int CS_SETUP  = SPI1_CS_SETUP,
    parameter int CS_HOLD   = SPI1_CS_HOLD,
    parameter int CS_GAP    = SPI1_CS_GAP
)
(
    input  logic                   clk_100m,
    input  logic                   rst_syn,
    input  logic [3:0]             req,
    input  logic [4*DATA_BITS-1:0] tx_data,
    output logic [3:0]             grant,
    output logic [3:0]             done,
    output logic [DATA_BITS-1:0]   rx_data,
    output logic                   busy,
    output logic                   mclk,
    output logic                   mosi,
    input  logic                   miso,
    output logic [3:0]             cs_n
);

    logic [1:0]           r_rr_ptr;
    logic [3:0]           r_grant;
    logic [2:0]           w_pick;
    logic                 w_start;
    logic                 w_eng_done;
    logic [DATA_BITS-1:0] w_slice [4];
    logic [DATA_BITS-1:0] w_tx_sel;

    for (genvar g = 0; g < 4; g++) begin : g_slice
        assign w_slice[g] = tx_data[g*DATA_BITS +: DATA_BITS];
    end

    assign w_pick   = rr_pick(req, r_rr_ptr);
    assign w_start  = w_pick[2] & ~busy;
    assign w_tx_sel = w_slice[w_pick[1:0]];

    // Grant spans the whole frame; chip select follows it exactly.
    always_ff @(posedge clk_100m) begin
        if (rst_syn) begin
            r_rr_ptr <= 2'd3;
            r_grant  <= 4'h0;
        end else if (w_start) begin
            r_rr_ptr <= w_pick[1:0];
            r_grant  <= 4'b0001 << w_pick[1:0];
        end else if (w_eng_done) begin
            r_grant  <= 4'h0;
        end
    end

    spi1_shift_engine #(
        .DATA_BITS (DATA_BITS),
        .SCLK_HALF (SCLK_HALF),
        .CS_SETUP  (CS_SETUP),
        .CS_HOLD   (CS_HOLD),
        .CS_GAP    (CS_GAP)
    ) u_engine (
        .clk_100m (clk_100m),
        .rst_syn  (rst_syn),
        .i_start  (w_start),
        .i_tx     (w_tx_sel),
        .i_miso   (miso),
        .o_busy   (busy),
        .o_done   (w_eng_done),
        .o_mclk   (mclk),
        .o_mosi   (mosi),
        .o_rx     (rx_data)
    );

    assign grant = r_grant;
    assign cs_n  = ~r_grant;
    assign done  = r_grant & {4{w_eng_done}};

endmodule

// File: tb/tb_spi1_master_arbiter.sv
// Directed bench for spi1_master_arbiter: default-timing instance on loopback or
// tied miso, plus a fast-timing instance talking to a small mode-3 slave model.
module tb_spi1_master_arbiter;

    localparam int LAT     = 3220;
    localparam int SPACING = 3241;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   req_a, grant_a, done_a, cs_n_a;
    logic [127:0] tx_a;
    logic [31:0]  rx_a;
    logic         busy_a, mclk_a, mosi_a, miso_a, loop_a;

    logic [3:0]   req_b, grant_b, done_b, cs_n_b;
    logic [31:0]  tx_b;
    logic [7:0]   rx_b;
    logic         busy_b, mclk_b, mosi_b, miso_b;

    logic [7:0]   sl_sr = 8'h00;
    logic         sl_first = 1'b0;
    logic [7:0]   sl_rx = 8'h00;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int multi_cs = 0;

    assign miso_a = loop_a ? mosi_a : 1'b1;
    assign miso_b = sl_sr[7];

    spi1_master_arbiter u_dut_a (
        .clk_100m (clk),
        .rst_syn  (rst),
        .req      (req_a),
        .tx_data  (tx_a),
        .grant    (grant_a),
        .done     (done_a),
        .rx_data  (rx_a),
        .busy     (busy_a),
        .mclk     (mclk_a),
        .mosi     (mosi_a),
        .miso     (miso_a),
        .cs_n     (cs_n_a)
    );

    spi1_master_arbiter #(
        .DATA_BITS (8),
        .SCLK_HALF (2),
        .CS_SETUP  (1),
        .CS_HOLD   (1),
        .CS_GAP    (1)
    ) u_dut_b (
        .clk_100m (clk),
        .rst_syn  (rst),
        .req      (req_b),
        .tx_data  (tx_b),
        .grant    (grant_b),
        .done     (done_b),
        .rx_data  (rx_b),
        .busy     (busy_b),
        .mclk     (mclk_b),
        .mosi     (mosi_b),
        .miso     (miso_b),
        .cs_n     (cs_n_b)
    );

    // Slave: MSB presented at cs_n fall, advances on every mclk fall but the first.
    always @(negedge mclk_b or negedge cs_n_b[0]) begin
        if (mclk_b) begin
            sl_sr    <= 8'h3C;
            sl_first <= 1'b1;
        end else if (!cs_n_b[0]) begin
            if (sl_first) sl_first <= 1'b0;
            else          sl_sr    <= {sl_sr[6:0], 1'b0};
        end
    end

    always @(posedge mclk_b) sl_rx <= {sl_rx[6:0], mosi_b};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if ($countones(~cs_n_a) > 1) multi_cs <= multi_cs + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] exp_g, output int t_g);
        int n = 0;
        while (grant_a == 4'h0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_grant"}, 32'(grant_a), 32'(exp_g));
        t_g = cyc;
    endtask

    // Called on the first sample showing the grant; returns one cycle after done.
    task automatic wait_done(input string tag, input logic [3:0] exp_g, input logic [31:0] exp_rx,
                             input bit drop_req, input int alter_at);
        int   lat = 0;
        int   rises = 0;
        int   cs_bad = 0;
        logic pm;
        pm = mclk_a;
        while (done_a == 4'h0 && lat < 5000) begin
            @(negedge clk);
            lat++;
            if (mclk_a && !pm) rises++;
            pm = mclk_a;
            if (cs_n_a != ~exp_g) cs_bad++;
            if (lat == alter_at) begin
                req_a = 4'h0;
                tx_a  = {4{32'h12345678}};
            end
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(LAT));
        check_eq({tag, "_mclk_rises"}, 32'(rises), 32'd32);
        check_eq({tag, "_cs_steady"}, 32'(cs_bad), 32'd0);
        check_eq({tag, "_done"}, 32'(done_a), 32'(exp_g));
        check_eq({tag, "_rx"}, rx_a, exp_rx);
        if (drop_req) req_a = req_a & ~done_a;
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int tg, tprev, n, lat, rises, t1, t2, seen;
        logic pm;
        logic [3:0] eg;

        rst = 1'b1; req_a = 4'h0; tx_a = '0; loop_a = 1'b1;
        req_b = 4'h0; tx_b = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_grant", 32'(grant_a), 32'h0);
        check_eq("rst_done", 32'(done_a), 32'h0);
        check_eq("rst_rx", rx_a, 32'h0);
        check_eq("rst_busy", 32'(busy_a), 32'h0);
        check_eq("rst_mclk", 32'(mclk_a), 32'h1);
        check_eq("rst_mosi", 32'(mosi_a), 32'h1);
        check_eq("rst_cs", 32'(cs_n_a), 32'hF);
        check_eq("rst_b_cs", 32'(cs_n_b), 32'hF);
        check_eq("rst_b_mosi", 32'(mosi_b), 32'h1);
        rst = 1'b0;
        @(negedge clk);

        // Fast-timing instance against the slave model
        tx_b = 32'h000000A6; req_b = 4'b0001;
        n = 0;
        while (grant_b == 4'h0 && n < 100) begin @(negedge clk); n++; end
        check_eq("tm_grant", 32'(grant_b), 32'h1);
        lat = 0; rises = 0; t1 = 0; t2 = 0; pm = mclk_b;
        while (done_b == 4'h0 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (mclk_b && !pm) begin
                rises++;
                if (rises == 1) t1 = lat;
                if (rises == 2) t2 = lat;
            end
            pm = mclk_b;
        end
        check_eq("tm_latency", 32'(lat), 32'd34);
        check_eq("tm_mclk_rises", 32'(rises), 32'd8);
        check_eq("tm_mclk_period", 32'(t2 - t1), 32'd4);
        check_eq("tm_rx", 32'(rx_b), 32'h3C);
        check_eq("tm_done", 32'(done_b), 32'h1);
        check_eq("tm_busy", 32'(busy_b), 32'h1);
        req_b = 4'h0;
        repeat (4) @(negedge clk);
        check_eq("tm_slave_got_mosi", 32'(sl_rx), 32'hA6);

        // Single request on channel 2 with loopback
        tx_a[95:64] = 32'hA5A51234; req_a = 4'b0100;
        @(negedge clk);
        check_eq("t1_grant_next_cycle", 32'(grant_a), 32'h4);
        check_eq("t1_cs", 32'(cs_n_a), 32'hB);
        wait_done("t1", 4'b0100, 32'hA5A51234, 1'b1, -1);
        check_eq("t1_cs_release", 32'(cs_n_a), 32'hF);
        check_eq("t1_grant_release", 32'(grant_a), 32'h0);
        check_eq("t1_mosi_idle", 32'(mosi_a), 32'h1);
        check_eq("t1_done_one_cycle", 32'(done_a), 32'h0);

        // All four held from reset, miso tied high
        rst = 1'b1; req_a = 4'hF; loop_a = 1'b0;
        tx_a = {32'd3, 32'd2, 32'd1, 32'd0};
        @(negedge clk);
        rst = 1'b0;
        tprev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant($sformatf("t2_f%0d", k), 4'(1 << k), tg);
            if (k > 0) check_eq($sformatf("t2_spacing_f%0d", k), 32'(tg - tprev), 32'(SPACING));
            tprev = tg;
            wait_done($sformatf("t2_f%0d", k), 4'(1 << k), 32'hFFFFFFFF, 1'b1, -1);
        end

        // Fairness between channels 0 and 3
        rst = 1'b1; req_a = 4'b1001; loop_a = 1'b1;
        tx_a = {32'h3333AAAA, 32'h0, 32'h0, 32'h11110000};
        @(negedge clk);
        rst = 1'b0;
        for (int f = 0; f < 6; f++) begin
            eg = (f % 2 == 1) ? 4'b1000 : 4'b0001;
            wait_grant($sformatf("t3_f%0d", f), eg, tg);
            wait_done($sformatf("t3_f%0d", f), eg, (f % 2 == 1) ? 32'h3333AAAA : 32'h11110000, 1'b0, -1);
        end
        req_a = 4'h0;

        // Reset in the middle of a channel-1 shift
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; tx_a = '0; tx_a[63:32] = 32'h5A5A0F0F; req_a = 4'b0010;
        wait_grant("t4", 4'b0010, tg);
        seen = 0;
        repeat (10 + 1000) begin
            @(negedge clk);
            if (done_a != 4'h0) seen++;
        end
        check_eq("t4_mid_busy", 32'(busy_a), 32'h1);
        check_eq("t4_mid_mclk", 32'(mclk_a), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t4_rst_cs", 32'(cs_n_a), 32'hF);
        check_eq("t4_rst_mclk", 32'(mclk_a), 32'h1);
        check_eq("t4_rst_mosi", 32'(mosi_a), 32'h1);
        check_eq("t4_rst_busy", 32'(busy_a), 32'h0);
        check_eq("t4_rst_grant", 32'(grant_a), 32'h0);
        if (done_a != 4'h0) seen++;
        check_eq("t4_no_done", 32'(seen), 32'h0);
        wait_grant("t4b", 4'b0010, tg);
        wait_done("t4b", 4'b0010, 32'h5A5A0F0F, 1'b1, -1);

        // Request and data withdrawn mid-frame
        tx_a[63:32] = 32'hC0FFEE11; req_a = 4'b0010;
        wait_grant("t5", 4'b0010, tg);
        wait_done("t5", 4'b0010, 32'hC0FFEE11, 1'b0, 100);
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (grant_a != 4'h0) n++;
        end
        check_eq("t5_no_regrant", 32'(n), 32'h0);

        check_eq("cs_exclusive", 32'(multi_cs), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
